mem_write: RTL and testbench

- Stream-to-memory write stage. Sits directly downstream of the READ stage and consumes its valid_out/data_out stream.
- Drives the write port of a MEM instance: write, addr_write, data_write.
- Buffers incoming words in a small FIFO and issues one memory write per word to consecutive addresses.
- Total words per job = num_iters x num_writes_per_iter. Backpressure to upstream is given through avail_out, which connects to READ's avail_in.

---
 rtl/mem_write_pkg.sv | 17 +
 rtl/mem_write_fifo.sv | 83 ++++++++
 rtl/mem_write.sv | 207 ++++++++++++++++++++
 tb/tb_mem_write.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_pkg.sv
// Shared definitions for the memory write stage: FSM encoding and default
// widths, kept in line with the READ and MEM blocks.
package mem_write_pkg;

  localparam int DEF_DATA_WIDTH              = 8;
  localparam int DEF_LOG_MAX_ITERS           = 8;
  localparam int DEF_LOG_MAX_WRITES_PER_ITER = 16;
  localparam int DEF_LOG_MAX_ADDRESS         = 12;
  localparam int DEF_LOG_FIFO_DEPTH          = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_write_fifo.sv
// Synchronous FIFO with a combinational head word. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module mem_write_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CW    = LOG_DEPTH + 1;
  localparam int PW    = LOG_DEPTH;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;
  logic             full_s;

  // Next-state computation for storage, pointers and occupancy
  always_comb begin
    full_s    = (count_q == DEPTH_CNT);
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && (!full_s || do_pop_s);

    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_s;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mem_write.sv
// Stream-to-memory write stage: buffers upstream words and writes them to
// consecutive, wrapping addresses, num_iters x num_writes_per_iter per job.
module mem_write
  import mem_write_pkg::*;
#(
  parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int LOG_MAX_ITERS           = DEF_LOG_MAX_ITERS,
  parameter int LOG_MAX_WRITES_PER_ITER = DEF_LOG_MAX_WRITES_PER_ITER,
  parameter int LOG_MAX_ADDRESS         = DEF_LOG_MAX_ADDRESS,
  parameter int LOG_FIFO_DEPTH          = DEF_LOG_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               configure,
  input  logic [LOG_MAX_ITERS-1:0]           num_iters,
  input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
  input  logic                               valid_in,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic                               avail_out,
  input  logic                               hold,
  output logic                               write,
  output logic [LOG_MAX_ADDRESS-1:0]         address_out,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               done,
  output logic                               error
);

  localparam int LI = LOG_MAX_ITERS;
  localparam int LW = LOG_MAX_WRITES_PER_ITER;
  localparam int LA = LOG_MAX_ADDRESS;
  localparam int TW = LOG_MAX_ITERS + LOG_MAX_WRITES_PER_ITER;
  localparam int CW = LOG_FIFO_DEPTH + 1;
  // One slot is kept free for a word already launched by upstream.
  localparam logic [CW-1:0] AVAIL_LIMIT = CW'((1 << LOG_FIFO_DEPTH) - 2);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_e            state_q, state_d;
  logic [LI-1:0]     iters_q, iters_d;
  logic [LI-1:0]     iter_q, iter_d;
  logic [LW-1:0]     wpi_q, wpi_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [LA-1:0]     addr_q, addr_d;
  logic [TW-1:0]     total_q, total_d;
  logic [TW-1:0]     accepted_q, accepted_d;
  logic              write_q, write_d;
  logic [LA-1:0]     address_out_q, address_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic              avail_q, avail_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              in_run_s;
  logic              push_s;
  logic              pop_s;
  logic              last_write_s;
  logic [CW-1:0]     occ_next_s;
  logic [DATA_WIDTH-1:0] fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;

  mem_write_fifo #(
    .WIDTH     (DATA_WIDTH),
    .LOG_DEPTH (LOG_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (data_in),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Accept/write handshakes, FSM next state and registered output values
  always_comb begin
    in_run_s     = (state_q == ST_RUN);
    pop_s        = in_run_s && !fifo_empty_s && !hold;
    push_s       = in_run_s && valid_in && (accepted_q < total_q)
                   && (!fifo_full_s || pop_s);
    last_write_s = (iter_q == (iters_q - LI'(1))) && (idx_q == (wpi_q - LW'(1)));

    state_d       = state_q;
    iters_d       = iters_q;
    iter_d        = iter_q;
    wpi_d         = wpi_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    total_d       = total_q;
    accepted_d    = accepted_q;
    write_d       = 1'b0;
    address_out_d = address_out_q;
    data_out_d    = data_out_q;
    done_d        = 1'b0;
    // Any offered word that is not pushed is a protocol violation and is dropped.
    error_d       = error_q | (valid_in && !push_s);

    case (state_q)
      ST_IDLE: begin
        if (configure) begin
          iters_d    = num_iters;
          wpi_d      = num_writes_per_iter;
          addr_d     = base_address;
          total_d    = TW'(num_iters) * TW'(num_writes_per_iter);
          iter_d     = '0;
          idx_d      = '0;
          accepted_d = '0;
          if ((num_iters == '0) || (num_writes_per_iter == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (push_s) begin
          accepted_d = accepted_q + TW'(1);
        end else begin
          accepted_d = accepted_q;
        end
        if (pop_s) begin
          write_d       = 1'b1;
          address_out_d = addr_q;
          data_out_d    = fifo_dout_s;
          addr_d        = addr_q + LA'(1);
          if (idx_q == (wpi_q - LW'(1))) begin
            idx_d  = '0;
            iter_d = iter_q + LI'(1);
          end else begin
            idx_d  = idx_q + LW'(1);
            iter_d = iter_q;
          end
          if (last_write_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   occ_next_s = fifo_count_s + CNT_ONE;
      2'b01:   occ_next_s = fifo_count_s - CNT_ONE;
      default: occ_next_s = fifo_count_s;
    endcase

    avail_d = (state_d == ST_RUN) && (occ_next_s <= AVAIL_LIMIT) && (accepted_d < total_d);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      iters_q       <= '0;
      iter_q        <= '0;
      wpi_q         <= '0;
      idx_q         <= '0;
      addr_q        <= '0;
      total_q       <= '0;
      accepted_q    <= '0;
      write_q       <= 1'b0;
      address_out_q <= '0;
      data_out_q    <= '0;
      avail_q       <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      iters_q       <= iters_d;
      iter_q        <= iter_d;
      wpi_q         <= wpi_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      total_q       <= total_d;
      accepted_q    <= accepted_d;
      write_q       <= write_d;
      address_out_q <= address_out_d;
      data_out_q    <= data_out_d;
      avail_q       <= avail_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign write       = write_q;
  assign address_out = address_out_q;
  assign data_out    = data_out_q;
  assign avail_out   = avail_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_mem_write.sv
// Directed bench for mem_write: a table of jobs driven through an
// avail-respecting upstream model, plus reset and protocol-violation sequences.
module tb_mem_write;

  localparam int DW = 8;
  localparam int LI = 8;
  localparam int LW = 16;
  localparam int LA = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          configure;
  logic [LI-1:0] num_iters;
  logic [LW-1:0] num_writes_per_iter;
  logic [LA-1:0] base_address;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          avail_out;
  logic          hold;
  logic          write;
  logic [LA-1:0] address_out;
  logic [DW-1:0] data_out;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_write #(
    .DATA_WIDTH              (DW),
    .LOG_MAX_ITERS           (LI),
    .LOG_MAX_WRITES_PER_ITER (LW),
    .LOG_MAX_ADDRESS         (LA),
    .LOG_FIFO_DEPTH          (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .configure           (configure),
    .num_iters           (num_iters),
    .num_writes_per_iter (num_writes_per_iter),
    .base_address        (base_address),
    .valid_in            (valid_in),
    .data_in             (data_in),
    .avail_out           (avail_out),
    .hold                (hold),
    .write               (write),
    .address_out         (address_out),
    .data_out            (data_out),
    .done                (done),
    .error               (error)
  );

  typedef struct {
    int base;
    int iters;
    int wpi;
    int hold_start;
    int hold_len;
    int seed;
    int exp_writes;
    int exp_last_addr;
  } job_t;

  job_t jobs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one job from the table; abort_after >= 0 pulls reset after that many writes.
  task automatic run_job(input int j, input int abort_after);
    job_t c;
    int   total, cyc, wcount, sent, done_cnt, done_at, first_wr, last_wr, last_addr, hold_writes;
    bit   avail_ever, avail_low, prev_hold, finished;
    c = jobs[j];
    total = c.iters * c.wpi;
    cyc = 0; wcount = 0; sent = 0; done_cnt = 0; done_at = -1;
    first_wr = -1; last_wr = -1; last_addr = -1; hold_writes = 0;
    avail_ever = 1'b0; avail_low = 1'b0; prev_hold = 1'b0; finished = 1'b0;

    @(negedge clk);
    configure           = 1'b1;
    num_iters           = LI'(c.iters);
    num_writes_per_iter = LW'(c.wpi);
    base_address        = LA'(c.base);
    valid_in            = 1'b0;
    hold                = 1'b0;

    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      configure = 1'b0;
      if (write) begin
        if (prev_hold) hold_writes++;
        if (first_wr < 0) first_wr = cyc;
        last_wr   = cyc;
        last_addr = int'(address_out);
        chk("wr_addr", 32'(address_out), 32'((c.base + wcount) % 4096));
        chk("wr_data", 32'(data_out), 32'((c.seed + wcount) % 256));
        wcount++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (avail_out) avail_ever = 1'b1;
      if (prev_hold && !avail_out) avail_low = 1'b1;

      if (abort_after >= 0 && wcount == abort_after) begin
        rst      = 1'b0;
        valid_in = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_avail", 32'(avail_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("post_rst_write", 32'(write), 32'd0);
          chk("post_rst_avail", 32'(avail_out), 32'd0);
        end
        return;
      end

      if (done_at >= 0 && cyc >= done_at + 3) finished = 1'b1;
      hold      = (c.hold_len > 0) && (cyc >= c.hold_start) && (cyc < c.hold_start + c.hold_len);
      prev_hold = hold;
      if (avail_out && sent < total) begin
        valid_in = 1'b1;
        data_in  = DW'(c.seed + sent);
        sent++;
      end else begin
        valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    hold     = 1'b0;

    chk("job_finished", 32'(finished), 32'd1);
    chk("write_count", 32'(wcount), 32'(c.exp_writes));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("error_clear", 32'(error), 32'd0);
    if (c.exp_writes > 0) begin
      chk("first_write_latency", 32'(first_wr), 32'd3);
      chk("last_addr", 32'(last_addr), 32'(c.exp_last_addr));
      chk("done_after_last", 32'(done_at), 32'(last_wr + 1));
    end else begin
      chk("zero_done_at", 32'(done_at), 32'd2);
      chk("zero_avail", 32'(avail_ever), 32'd0);
    end
    if (c.hold_len > 0) begin
      chk("hold_writes", 32'(hold_writes), 32'd0);
      chk("hold_avail_low", 32'(avail_low), 32'd1);
    end
  endtask

  initial begin
    int wc, dc;

    jobs[0] = '{32,   4, 16, 0, 0,  0,   64, 95};
    jobs[1] = '{100,  2, 20, 8, 10, 16,  40, 139};
    jobs[2] = '{4090, 1, 10, 0, 0,  64,  10, 3};
    jobs[3] = '{7,    0, 5,  0, 0,  0,   0,  0};
    jobs[4] = '{9,    3, 0,  0, 0,  0,   0,  0};
    jobs[5] = '{0,    1, 1,  0, 0,  200, 1,  0};

    rst = 1'b0; configure = 1'b0; num_iters = '0; num_writes_per_iter = '0;
    base_address = '0; valid_in = 1'b0; data_in = '0; hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_write", 32'(write), 32'd0);
    chk("reset_addr", 32'(address_out), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_avail", 32'(avail_out), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    rst = 1'b1;

    for (int j = 0; j < 6; j++) begin
      run_job(j, -1);
    end

    run_job(0, 20);
    run_job(0, -1);

    // Fifth word offered to a four-word job while writes are still draining.
    @(negedge clk);
    configure = 1'b1; num_iters = 8'd1; num_writes_per_iter = 16'd4;
    base_address = 12'd50; valid_in = 1'b0; hold = 1'b0;
    wc = 0; dc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      configure = 1'b0;
      if (write) begin
        chk("ovf_addr", 32'(address_out), 32'(50 + wc));
        chk("ovf_data", 32'(data_out), 32'(160 + wc));
        wc++;
      end
      if (done) dc++;
      if (i == 4) chk("ovf_err_before", 32'(error), 32'd0);
      if (i == 5) chk("ovf_err_set", 32'(error), 32'd1);
      valid_in = (i < 5);
      data_in  = DW'(160 + i);
    end
    valid_in = 1'b0;
    chk("ovf_writes", 32'(wc), 32'd4);
    chk("ovf_done", 32'(dc), 32'd1);
    chk("ovf_err_sticky", 32'(error), 32'd1);

    // Word offered while idle.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_error", 32'(error), 32'd0);
    rst = 1'b1;
    valid_in = 1'b1; data_in = 8'h55;
    @(negedge clk);
    valid_in = 1'b0;
    chk("idle_err_set", 32'(error), 32'd1);
    chk("idle_no_write", 32'(write), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_err_sticky", 32'(error), 32'd1);
    chk("idle_still_no_write", 32'(write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
